// File: rtl/sync_analyzer.sv
// Receive-side timing analyzer for the latched TVP7002 HSYNC/VSYNC/FID stream.
// Latency: results update on the cycle after the internal edge-detect cycle.
// No backpressure: runs freely on PCLK_in. Optional FID_IN_EN takes field parity from FID_in.
module sync_analyzer #(
  parameter int HDIFF_TOL    = 2,
  parameter int STABLE_LINES = 4
) (
  input  logic        PCLK_in,
  input  logic        hw_reset_n,
  input  logic        HSYNC_in,
  input  logic        VSYNC_in,
  input  logic        FID_in,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
  output logic [19:0] pcnt_frame,
  output logic        ilace_flag,
  output logic        vsync_flag,
  output logic        h_unstable
);

  localparam int          SW   = $clog2(STABLE_LINES + 1);
  localparam logic [11:0] TOL  = 12'(HDIFF_TOL);
  localparam logic [SW-1:0] STAB = SW'(STABLE_LINES);

  // Registered current and previous sync levels; idle level is high.
  logic hs_q, hs_p, vs_q, vs_p, fid_q;

  logic [11:0]   hcnt;
  logic [11:0]   h_prev;
  logic [SW-1:0] stab_cnt;
  logic          h_skip;      // next hs edge only restarts the line (after reset/timeout)

  logic [10:0]   vcnt;
  logic [19:0]   pcnt;
  logic          v_armed;     // a field start has been seen, so the next field is complete
  logic          phase_valid; // a previous field phase exists to compare against
  logic          phase_prev;

  logic          hs_edge, vs_edge;
  logic [11:0]   h_meas, h_diff;
  logic          h_in_tol;
  logic [SW-1:0] stab_nxt;
  logic [10:0]   vcnt_p1;
  logic [19:0]   pcnt_p1;
  logic          cur_phase;

  assign hs_edge = hs_p & ~hs_q;
  assign vs_edge = vs_p & ~vs_q;

  assign h_meas   = (hcnt == 12'hFFF) ? 12'hFFF : hcnt + 12'd1;
  assign h_diff   = (h_meas >= h_prev) ? (h_meas - h_prev) : (h_prev - h_meas);
  assign h_in_tol = (h_diff <= TOL);
  assign stab_nxt = (stab_cnt == STAB) ? stab_cnt : stab_cnt + 1'b1;

  assign vcnt_p1 = (vcnt == 11'h7FF) ? 11'h7FF : vcnt + 11'd1;
  assign pcnt_p1 = (pcnt == 20'hFFFFF) ? 20'hFFFFF : pcnt + 20'd1;

`ifdef FID_IN_EN
  // Field parity comes straight from the decoder's field ID.
  assign cur_phase = fid_q;
`else
  // Field parity: VSYNC falling in the second half of a line marks the other field.
  logic fid_unused;
  assign fid_unused = fid_q;
  assign cur_phase  = (hcnt >= {1'b0, h_total[11:1]});
`endif

  // Sample sync inputs and keep their previous values for falling-edge detection.
  always_ff @(posedge PCLK_in or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      hs_q  <= 1'b1;
      hs_p  <= 1'b1;
      vs_q  <= 1'b1;
      vs_p  <= 1'b1;
      fid_q <= 1'b0;
    end else begin
      hs_q  <= HSYNC_in;
      hs_p  <= hs_q;
      vs_q  <= VSYNC_in;
      vs_p  <= vs_q;
      fid_q <= FID_in;
    end
  end

  // Horizontal: measure line length, track stability, detect missing HSYNC.
  always_ff @(posedge PCLK_in or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      hcnt       <= '0;
      h_prev     <= '0;
      stab_cnt   <= '0;
      h_skip     <= 1'b1;
      h_total    <= '0;
      h_unstable <= 1'b1;
    end else if (hs_edge) begin
      hcnt   <= '0;
      h_prev <= h_meas;
      if (h_skip) begin
        // Partial line after reset or timeout: only seeds the comparison.
        h_skip <= 1'b0;
      end else begin
        h_total <= h_meas;
        if (!h_in_tol) begin
          h_unstable <= 1'b1;
          stab_cnt   <= '0;
        end else begin
          stab_cnt <= stab_nxt;
          if (stab_nxt == STAB) begin
            h_unstable <= 1'b0;
          end
        end
      end
    end else if (hcnt != 12'hFFF) begin
      hcnt <= hcnt + 12'd1;
      if (hcnt == 12'hFFE) begin
        // Line ran out of range: HSYNC considered missing.
        h_unstable <= 1'b1;
        stab_cnt   <= '0;
        h_total    <= '0;
        h_skip     <= 1'b1;
      end
    end
  end

  // Vertical: count lines and pixels per field, field-parity/interlace detection.
  always_ff @(posedge PCLK_in or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      vcnt        <= '0;
      pcnt        <= '0;
      v_total     <= '0;
      pcnt_frame  <= '0;
      vsync_flag  <= 1'b0;
      ilace_flag  <= 1'b0;
      v_armed     <= 1'b0;
      phase_valid <= 1'b0;
      phase_prev  <= 1'b0;
    end else if (vs_edge) begin
      vcnt       <= '0;
      pcnt       <= '0;
      vsync_flag <= ~vsync_flag;
      v_armed    <= 1'b1;
      if (v_armed) begin
        // A line ending together with VSYNC belongs to the field that ends.
        v_total    <= hs_edge ? vcnt_p1 : vcnt;
        pcnt_frame <= pcnt_p1;
      end
      phase_prev  <= cur_phase;
      phase_valid <= 1'b1;
      if (phase_valid) begin
        ilace_flag <= (cur_phase != phase_prev);
      end
    end else begin
      pcnt <= pcnt_p1;
      if (hs_edge && (vcnt != 11'h7FF)) begin
        vcnt <= vcnt + 11'd1;
        if (vcnt == 11'h7FE) begin
          // Field ran out of range: VSYNC considered missing.
          v_total     <= '0;
          pcnt_frame  <= 20'hFFFFF;
          ilace_flag  <= 1'b0;
          phase_valid <= 1'b0;
          v_armed     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_analyzer.sv
// Directed bench for sync_analyzer: table-driven line-length sequence plus
// hand-written progressive, interlaced, timeout, coincident-edge, reset and FID sequences.
// Inputs are driven on the falling clock edge; outputs are checked on the falling edge.
module tb_sync_analyzer;

  localparam int HSW = 8;   // HSYNC low width in cycles
  localparam int VSW = 16;  // VSYNC low width in cycles

`ifdef FID_IN_EN
  localparam int FID_ILACE_EXP = 1;
`else
  localparam int FID_ILACE_EXP = 0;
`endif

  logic        PCLK_in = 1'b0;
  logic        hw_reset_n = 1'b0;
  logic        HSYNC_in = 1'b1;
  logic        VSYNC_in = 1'b1;
  logic        FID_in = 1'b0;
  logic [11:0] h_total;
  logic [10:0] v_total;
  logic [19:0] pcnt_frame;
  logic        ilace_flag;
  logic        vsync_flag;
  logic        h_unstable;

  int n_chk  = 0;
  int n_pass = 0;
  int vs_left = 0;

  typedef struct {
    int          len;
    bit          chk;
    logic [11:0] ht;
    logic        unst;
  } hvec_t;

  hvec_t tbl[$];

  always #5 PCLK_in = ~PCLK_in;

  sync_analyzer dut (
    .PCLK_in    (PCLK_in),
    .hw_reset_n (hw_reset_n),
    .HSYNC_in   (HSYNC_in),
    .VSYNC_in   (VSYNC_in),
    .FID_in     (FID_in),
    .h_total    (h_total),
    .v_total    (v_total),
    .pcnt_frame (pcnt_frame),
    .ilace_flag (ilace_flag),
    .vsync_flag (vsync_flag),
    .h_unstable (h_unstable)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".h_total"},    int'(h_total),    0);
    check({tag, ".v_total"},    int'(v_total),    0);
    check({tag, ".pcnt_frame"}, int'(pcnt_frame), 0);
    check({tag, ".ilace_flag"}, int'(ilace_flag), 0);
    check({tag, ".vsync_flag"}, int'(vsync_flag), 0);
    check({tag, ".h_unstable"}, int'(h_unstable), 1);
  endtask

  // One line of len cycles; HSYNC falls at p=0, VSYNC falls at p=vs_off (-1: none).
  task automatic drive_line(input int len, input int vs_off, input logic fid);
    for (int p = 0; p < len; p++) begin
      @(negedge PCLK_in);
      HSYNC_in = (p < HSW) ? 1'b0 : 1'b1;
      if (p == vs_off) vs_left = VSW;
      VSYNC_in = (vs_left > 0) ? 1'b0 : 1'b1;
      if (vs_left > 0) vs_left--;
      FID_in = fid;
    end
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK_in);
      HSYNC_in = 1'b1;
      VSYNC_in = 1'b1;
      vs_left  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge PCLK_in);
    hw_reset_n = 1'b0;
    HSYNC_in   = 1'b1;
    VSYNC_in   = 1'b1;
    FID_in     = 1'b0;
    vs_left    = 0;
    repeat (3) @(negedge PCLK_in);
    hw_reset_n = 1'b1;
  endtask

  initial begin
    // ---------------- reset values ----------------
    repeat (3) @(negedge PCLK_in);
    check_reset("rst_init");
    hw_reset_n = 1'b1;

    // ---------------- progressive 858 x 4 lines ----------------
    do_reset();
    drive_line(858, 0, 1'b0);
    drive_line(858, -1, 1'b0);
    check("prog.unstable_early", int'(h_unstable), 1);
    check("prog.v_total_first_field", int'(v_total), 0);
    drive_line(858, -1, 1'b0);
    drive_line(858, -1, 1'b0);
    for (int f = 1; f < 4; f++) begin
      for (int l = 0; l < 4; l++) drive_line(858, (l == 0) ? 0 : -1, 1'b0);
    end
    drive_line(858, 0, 1'b0);
    check("prog.h_total",    int'(h_total),    858);
    check("prog.v_total",    int'(v_total),    4);
    check("prog.pcnt_frame", int'(pcnt_frame), 3432);
    check("prog.ilace",      int'(ilace_flag), 0);
    check("prog.vsync_flag", int'(vsync_flag), 1);
    check("prog.unstable",   int'(h_unstable), 0);

    // ---------------- interlaced: 9-line frames, VSYNC at half line on odd fields ----------------
    do_reset();
    for (int fr = 0; fr < 2; fr++) begin
      for (int l = 0; l < 9; l++) begin
        drive_line(858, (l == 0) ? 0 : ((l == 4) ? 429 : -1), (l >= 4) ? 1'b1 : 1'b0);
        if (fr == 0 && l == 4) begin
          check("ilace.f2_flag",    int'(ilace_flag), 1);
          check("ilace.f2_v_total", int'(v_total),    4);
        end
      end
    end
    check("ilace.odd_v_total", int'(v_total),    4);
    check("ilace.odd_flag",    int'(ilace_flag), 1);
    drive_line(858, 0, 1'b0);
    check("ilace.even_v_total", int'(v_total),    5);
    check("ilace.pcnt_frame",   int'(pcnt_frame), 3861);
    check("ilace.even_flag",    int'(ilace_flag), 1);

    // ---------------- line-length stability table ----------------
    for (int i = 0; i < 6; i++) tbl.push_back('{858, 1'b0, 12'd0, 1'b0});
    tbl.push_back('{858, 1'b1, 12'd858, 1'b0});
    tbl.push_back('{859, 1'b1, 12'd858, 1'b0});
    tbl.push_back('{857, 1'b1, 12'd859, 1'b0});
    tbl.push_back('{858, 1'b1, 12'd857, 1'b0});
    tbl.push_back('{864, 1'b1, 12'd858, 1'b0});
    tbl.push_back('{864, 1'b1, 12'd864, 1'b1});
    tbl.push_back('{864, 1'b1, 12'd864, 1'b1});
    tbl.push_back('{864, 1'b1, 12'd864, 1'b1});
    tbl.push_back('{864, 1'b1, 12'd864, 1'b1});
    tbl.push_back('{858, 1'b1, 12'd864, 1'b0});
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive_line(tbl[i].len, -1, 1'b0);
      if (tbl[i].chk) begin
        check($sformatf("stab[%0d].h_total", i),  int'(h_total),    int'(tbl[i].ht));
        check($sformatf("stab[%0d].unstable", i), int'(h_unstable), int'(tbl[i].unst));
      end
    end

    // ---------------- missing HSYNC and recovery ----------------
    do_reset();
    for (int i = 0; i < 7; i++) drive_line(858, -1, 1'b0);
    drive_idle(3000);
    check("hto.before_h_total",  int'(h_total),    858);
    check("hto.before_unstable", int'(h_unstable), 0);
    drive_idle(300);
    check("hto.h_total",  int'(h_total),    0);
    check("hto.unstable", int'(h_unstable), 1);
    drive_line(858, -1, 1'b0);
    check("hto.resume_h_total", int'(h_total), 0);
    for (int i = 0; i < 4; i++) drive_line(858, -1, 1'b0);
    check("hto.line4_unstable", int'(h_unstable), 1);
    check("hto.line4_h_total",  int'(h_total),    858);
    drive_line(858, -1, 1'b0);
    check("hto.line5_unstable", int'(h_unstable), 0);

    // ---------------- coincident HSYNC/VSYNC edges, then reset mid-field ----------------
    do_reset();
    drive_line(40, 0, 1'b0);
    for (int i = 0; i < 30; i++) drive_line(40, -1, 1'b0);
    drive_line(40, 0, 1'b0);
    check("sim.v_total",    int'(v_total),    31);
    check("sim.pcnt_frame", int'(pcnt_frame), 1240);
    drive_line(40, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive_line(40, -1, 1'b0);
    check("sim.one_line_v_total", int'(v_total),    1);
    check("sim.vsync_flag",       int'(vsync_flag), 1);
    @(negedge PCLK_in);
    hw_reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (2) @(negedge PCLK_in);
    hw_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) drive_line(40, -1, 1'b0);
    check("rst.partial_v_total", int'(v_total), 0);
    drive_line(40, 0, 1'b0);
    check("rst.first_vs_v_total",    int'(v_total),    0);
    check("rst.first_vs_pcnt_frame", int'(pcnt_frame), 0);
    for (int i = 0; i < 30; i++) drive_line(40, -1, 1'b0);
    drive_line(40, 0, 1'b0);
    check("rst.full_v_total",    int'(v_total),    31);
    check("rst.full_pcnt_frame", int'(pcnt_frame), 1240);

    // ---------------- progressive timing with FID toggling per field ----------------
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 8; l++) drive_line(40, (l == 0) ? 0 : -1, f[0]);
    end
    drive_line(40, 0, 1'b1);
    check("fid.v_total", int'(v_total),    8);
    check("fid.ilace",   int'(ilace_flag), FID_ILACE_EXP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
